// File: rtl/control_riesgos.sv
// control_riesgos: pipeline control for the 5-stage filter processor.
// Drives the load enables and bubble (flush) inputs of the pipeline registers.
// It resolves the load-use interlock, multi-cycle data-memory waits with a
// timeout, and taken-branch squash. It also keeps a saturating count of
// stalled cycles.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   Ra_F_Reg, Rb_F_Reg            sources of the instruction in F/Reg
//   RE_A_F_Reg, RE_B_F_Reg        source-read flags of the instruction in F/Reg
//   Robj_Reg_Exe, mem_RE_Reg_Exe  destination and load flag of the instruction in Reg/Exe
//   branch_taken_Exe              branch resolved taken in Exe
//   mem_req_Exe_Mem, mem_ack      data-memory request and completion
//   en_*                          pipeline register load enables (combinational)
//   flush_F_Reg, flush_Reg_Exe    load a bubble instead of data (combinational)
//   mem_error                     sticky memory timeout flag (registered)
//   stall_count                   saturating count of cycles with en_PC=0 (registered)
module control_riesgos #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       Ra_F_Reg,
  input  logic [3:0]       Rb_F_Reg,
  input  logic             RE_A_F_Reg,
  input  logic             RE_B_F_Reg,
  input  logic [3:0]       Robj_Reg_Exe,
  input  logic             mem_RE_Reg_Exe,
  input  logic             branch_taken_Exe,
  input  logic             mem_req_Exe_Mem,
  input  logic             mem_ack,
  output logic             en_PC,
  output logic             en_F_Reg,
  output logic             en_Reg_Exe,
  output logic             en_Exe_Mem,
  output logic             en_Mem_WB,
  output logic             flush_F_Reg,
  output logic             flush_Reg_Exe,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              memstall;
  logic              loaduse;

  // Freeze while a memory access is outstanding or after a timeout.
  always_comb begin
    memstall = 1'b0;
    case (state)
      RUN:      memstall = mem_req_Exe_Mem & ~mem_ack;
      MEM_WAIT: memstall = ~mem_ack;
      ERROR:    memstall = 1'b1;
      default:  memstall = 1'b1;
    endcase
  end

  // Load in Exe whose destination is read by the instruction behind it; R0 included.
  always_comb begin
    loaduse = mem_RE_Reg_Exe &
              ((RE_A_F_Reg & (Ra_F_Reg == Robj_Reg_Exe)) |
               (RE_B_F_Reg & (Rb_F_Reg == Robj_Reg_Exe)));
  end

  // Enables and flushes in priority order: reset, freeze, branch, load-use.
  always_comb begin
    en_PC         = 1'b1;
    en_F_Reg      = 1'b1;
    en_Reg_Exe    = 1'b1;
    en_Exe_Mem    = 1'b1;
    en_Mem_WB     = 1'b1;
    flush_F_Reg   = 1'b0;
    flush_Reg_Exe = 1'b0;
    if (rst) begin
      en_PC         = 1'b0;
      en_F_Reg      = 1'b0;
      en_Reg_Exe    = 1'b0;
      en_Exe_Mem    = 1'b0;
      en_Mem_WB     = 1'b0;
      flush_F_Reg   = 1'b1;
      flush_Reg_Exe = 1'b1;
    end else if (memstall) begin
      en_PC         = 1'b0;
      en_F_Reg      = 1'b0;
      en_Reg_Exe    = 1'b0;
      en_Exe_Mem    = 1'b0;
      en_Mem_WB     = 1'b0;
    end else if (branch_taken_Exe) begin
      // Squashing the younger instructions also drops any load-use on them.
      flush_F_Reg   = 1'b1;
      flush_Reg_Exe = 1'b1;
    end else if (loaduse) begin
      en_PC         = 1'b0;
      en_F_Reg      = 1'b0;
      flush_Reg_Exe = 1'b1;
    end
  end

  // Memory-wait state machine; wait_cnt holds the index of the current wait cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req_Exe_Mem && !mem_ack) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state     <= ERROR;
            mem_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ERROR: begin
          state     <= ERROR;
          mem_error <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter for performance monitoring.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!en_PC && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_riesgos.sv
// Bench for control_riesgos: two instances (MAX_WAIT=15/CNT_W=16 and
// MAX_WAIT=3/CNT_W=4) share the same stimulus and are checked every cycle
// against a behavioural model, plus directed scenarios with literal values.
module tb_control_riesgos;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ra, rb, robj;
  logic       re_a, re_b, mem_re, br, req, ack;

  logic en_pc0, en_fr0, en_re0, en_em0, en_mw0, fl_fr0, fl_re0, err0;
  logic en_pc1, en_fr1, en_re1, en_em1, en_mw1, fl_fr1, fl_re1, err1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic [6:0]  ctl0, ctl1;

  assign ctl0 = {en_pc0, en_fr0, en_re0, en_em0, en_mw0, fl_fr0, fl_re0};
  assign ctl1 = {en_pc1, en_fr1, en_re1, en_em1, en_mw1, fl_fr1, fl_re1};

  always #5 clk = ~clk;

  control_riesgos #(.MAX_WAIT(15), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst),
    .Ra_F_Reg(ra), .Rb_F_Reg(rb), .RE_A_F_Reg(re_a), .RE_B_F_Reg(re_b),
    .Robj_Reg_Exe(robj), .mem_RE_Reg_Exe(mem_re), .branch_taken_Exe(br),
    .mem_req_Exe_Mem(req), .mem_ack(ack),
    .en_PC(en_pc0), .en_F_Reg(en_fr0), .en_Reg_Exe(en_re0), .en_Exe_Mem(en_em0),
    .en_Mem_WB(en_mw0), .flush_F_Reg(fl_fr0), .flush_Reg_Exe(fl_re0),
    .mem_error(err0), .stall_count(cnt0)
  );

  control_riesgos #(.MAX_WAIT(3), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst),
    .Ra_F_Reg(ra), .Rb_F_Reg(rb), .RE_A_F_Reg(re_a), .RE_B_F_Reg(re_b),
    .Robj_Reg_Exe(robj), .mem_RE_Reg_Exe(mem_re), .branch_taken_Exe(br),
    .mem_req_Exe_Mem(req), .mem_ack(ack),
    .en_PC(en_pc1), .en_F_Reg(en_fr1), .en_Reg_Exe(en_re1), .en_Exe_Mem(en_em1),
    .en_Mem_WB(en_mw1), .flush_F_Reg(fl_fr1), .flush_Reg_Exe(fl_re1),
    .mem_error(err1), .stall_count(cnt1)
  );

  int checks = 0;
  int errors = 0;

  // Model state per instance: age = cycles the current access has already been pending.
  int          m_age [2];
  bit          m_err [2];
  int unsigned m_cnt [2];
  bit          m_valid = 1'b0;

  function automatic int unsigned max_wait(input int i);
    return (i == 0) ? 15 : 3;
  endfunction

  function automatic int unsigned cnt_max(input int i);
    return (i == 0) ? 65535 : 15;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {en_PC,en_F_Reg,en_Reg_Exe,en_Exe_Mem,en_Mem_WB,flush_F_Reg,flush_Reg_Exe}.
  function automatic logic [6:0] exp_ctl(input int i);
    bit frozen, lu;
    frozen = m_err[i] || ((m_age[i] > 0) ? !ack : (req && !ack));
    lu = mem_re && ((re_a && (ra == robj)) || (re_b && (rb == robj)));
    if (rst)         return 7'b00000_11;
    else if (frozen) return 7'b00000_00;
    else if (br)     return 7'b11111_11;
    else if (lu)     return 7'b00111_01;
    else             return 7'b11111_00;
  endfunction

  task automatic model_check_step();
    logic [6:0] e;
    for (int i = 0; i < 2; i++) begin
      e = exp_ctl(i);
      chk($sformatf("ctl%0d", i), (i == 0) ? 32'(ctl0) : 32'(ctl1), 32'(e));
      if (m_valid) begin
        chk($sformatf("mem_error%0d", i), (i == 0) ? 32'(err0) : 32'(err1), 32'(m_err[i]));
        chk($sformatf("stall_count%0d", i), (i == 0) ? 32'(cnt0) : 32'(cnt1), m_cnt[i]);
      end
      if (rst) begin
        m_age[i] = 0;
        m_err[i] = 1'b0;
        m_cnt[i] = 0;
      end else begin
        if (e[6] == 1'b0)
          m_cnt[i] = (m_cnt[i] == cnt_max(i)) ? cnt_max(i) : m_cnt[i] + 1;
        if (!m_err[i]) begin
          if (m_age[i] > 0) begin
            if (ack) m_age[i] = 0;
            else if (m_age[i] >= int'(max_wait(i))) m_err[i] = 1'b1;
            else m_age[i]++;
          end else if (req && !ack) begin
            m_age[i] = 1;
          end
        end
      end
    end
    if (rst) m_valid = 1'b1;
  endtask

  // One clock: compare on the falling edge, then move past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    model_check_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; ra = 4'd0; rb = 4'd0; robj = 4'd0;
    re_a = 1'b0; re_b = 1'b0; mem_re = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    // Reset held for two cycles.
    rst = 1'b1;
    #1 chk("reset_ctl", 32'(ctl0), 32'h03);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("post_reset_ctl", 32'(ctl0), 32'h7C);
    chk("post_reset_cnt", 32'(cnt0), 0);
    chk("post_reset_err", 32'(err0), 0);

    // Load-use on source A.
    mem_re = 1'b1; robj = 4'd3; ra = 4'd3; re_a = 1'b1;
    #1 chk("loaduse_ctl", 32'(ctl0), 32'h1D);
    cycle();
    mem_re = 1'b0;
    #1 chk("loaduse_after_ctl", 32'(ctl0), 32'h7C);
    chk("loaduse_cnt", 32'(cnt0), 1);
    cycle();
    mem_re = 1'b1; re_a = 1'b0;
    #1 chk("no_read_ctl", 32'(ctl0), 32'h7C);
    cycle();
    idle();
    #1 chk("no_read_cnt", 32'(cnt0), 1);

    // Memory access acked in request cycle 3.
    do_reset();
    req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("memwait_ctl", 32'(ctl0), 32'h00);
      cycle();
    end
    ack = 1'b1;
    #1 chk("memack_ctl", 32'(ctl0), 32'h7C);
    cycle();
    idle();
    #1 chk("memwait_cnt", 32'(cnt0), 3);
    req = 1'b1; ack = 1'b1;
    #1 chk("ack0_ctl", 32'(ctl0), 32'h7C);
    cycle();
    idle();
    #1 chk("ack0_cnt", 32'(cnt0), 3);

    // Branch together with load-use.
    br = 1'b1; mem_re = 1'b1; robj = 4'd5; rb = 4'd5; re_b = 1'b1;
    #1 chk("branch_lu_ctl", 32'(ctl0), 32'h7F);
    cycle();

    // Branch held during a freeze, ack in cycle 2.
    do_reset();
    req = 1'b1; br = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1 chk("branch_frozen_ctl", 32'(ctl0), 32'h00);
      cycle();
    end
    ack = 1'b1;
    #1 chk("branch_ack_ctl", 32'(ctl0), 32'h7F);
    cycle();

    // Timeout: 16 frozen cycles without ack.
    do_reset();
    req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1 chk("timeout_err_low", 32'(err0), 0);
      chk("timeout_frozen_ctl", 32'(ctl0), 32'h00);
      cycle();
    end
    req = 1'b0;
    #1 chk("timeout_err", 32'(err0), 1);
    chk("error_ctl", 32'(ctl0), 32'h00);
    cycle();
    do_reset();
    #1 chk("error_reset_err", 32'(err0), 0);
    chk("error_reset_ctl", 32'(ctl0), 32'h7C);

    // Saturation of the 4-bit counter over 20 frozen cycles.
    do_reset();
    req = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    idle();
    #1 chk("sat_cnt4", 32'(cnt1), 15);
    chk("cnt16_20", 32'(cnt0), 20);

    // Randomised segments with varying ack likelihood.
    for (int seg = 0; seg < 12; seg++) begin
      int unsigned ack_den;
      bit          narrow;
      ack_den = (seg % 4 == 0) ? 2 : (seg % 4 == 1) ? 5 : (seg % 4 == 2) ? 12 : 0;
      narrow  = (seg % 2 == 0);
      for (int c = 0; c < 150; c++) begin
        rst    = ($urandom_range(0, 79) == 0);
        ra     = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        rb     = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        robj   = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        re_a   = 1'($urandom_range(0, 1));
        re_b   = 1'($urandom_range(0, 1));
        mem_re = 1'($urandom_range(0, 1));
        br     = ($urandom_range(0, 7) == 0);
        req    = ($urandom_range(0, 2) == 0);
        ack    = (ack_den == 0) ? 1'b0 : ($urandom_range(0, ack_den - 1) == 0);
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
